// File: rtl/prbs_tx_pkg.sv
// Shared encodings for the PRBS frame transmitter and its sub-blocks.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package prbs_tx_pkg;

  localparam logic [1:0] MODE_PRBS = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_ALT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Selects the data bit for the given pattern mode.
  function automatic logic pattern_bit(input logic [1:0] mode,
                                       input logic       prbs_bit,
                                       input logic       alt_bit);
    logic b;
    case (mode)
      MODE_PRBS: b = prbs_bit;
      MODE_ZERO: b = 1'b0;
      MODE_ONE:  b = 1'b1;
      default:   b = alt_bit;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR, shift-left, polynomial x^POLY_LENGTH + x^POLY_TAP + 1.
// Latency: bit_out is the bit the register presents once this cycle's load/adv lands.
// Backpressure: none; advances only when adv is high, load has priority.
//
// Ports: clk, rst_n (async active-low, reloads all ones), load (reload all ones),
//        adv (one shift step), bit_out (look-ahead output bit, inverted when
//        INV_PATTERN=1). The look-ahead lets a caller register the new bit in
//        the same edge that moves the LFSR, so a bit boundary costs no extra cycle.
module prbs_lfsr #(
  parameter int POLY_LENGTH = 9,
  parameter int POLY_TAP    = 5,
  parameter int INV_PATTERN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  output logic bit_out
);

  localparam logic INV = (INV_PATTERN != 0);

  logic [POLY_LENGTH-1:0] lfsr_q;
  logic                   fb;
  logic                   next_msb;

  assign fb = lfsr_q[POLY_LENGTH-1] ^ lfsr_q[POLY_TAP-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '1;
    end else if (load) begin
      lfsr_q <= '1;
    end else if (adv) begin
      lfsr_q <= {lfsr_q[POLY_LENGTH-2:0], fb};
    end
  end

  // MSB after this edge: all ones on load, the shifted-up bit on adv.
  always_comb begin
    next_msb = lfsr_q[POLY_LENGTH-1];
    if (load) begin
      next_msb = 1'b1;
    end else if (adv) begin
      next_msb = lfsr_q[POLY_LENGTH-2];
    end
  end

  assign bit_out = next_msb ^ INV;

endmodule

// File: rtl/prbs_frame_tx.sv
// Sends one FRAME_LEN-bit test-pattern frame on a serial line at f_clk/(speedctr+1).
// Latency: start sampled in cycle T gives busy/bit_stb/bit 0 in T+1; done one cycle after the last busy cycle.
// Backpressure: none; send_start outside IDLE is dropped, not queued.
//
// Ports: clk, rst_n (async active-low), speedctr (rate divisor minus one),
//        mode (00 PRBS, 01 zeros, 10 ones, 11 alternating), send_start,
//        busy, done, bit_stb (first cycle of each bit), serial_out (idle 0).
// Optional: PRBS_TX_ERR_INJ_EN adds inj_err, which inverts the next presented bit.
module prbs_frame_tx
  import prbs_tx_pkg::*;
#(
  parameter int POLY_LENGTH = 9,
  parameter int POLY_TAP    = 5,
  parameter int INV_PATTERN = 1,
  parameter int FRAME_LEN   = 20000,
  parameter int DIV_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] speedctr,
  input  logic [1:0]       mode,
  input  logic             send_start,
`ifdef PRBS_TX_ERR_INJ_EN
  input  logic             inj_err,
`endif
  output logic             busy,
  output logic             done,
  output logic             bit_stb,
  output logic             serial_out
);

  localparam int             BCW      = $clog2(FRAME_LEN + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_LEN - 1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] spd_q;
  logic [DIV_W-1:0] rate_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic             alt_q;

  logic wrap;
  logic last;
  logic lfsr_load;
  logic lfsr_adv;
  logic prbs_bit;
  logic flip;

  assign wrap      = (state == ST_SEND) && (rate_cnt == spd_q);
  assign last      = wrap && (bit_cnt == LAST_BIT);
  assign lfsr_load = (state == ST_IDLE) && send_start;
  assign lfsr_adv  = wrap && !last;

  prbs_lfsr #(
    .POLY_LENGTH (POLY_LENGTH),
    .POLY_TAP    (POLY_TAP),
    .INV_PATTERN (INV_PATTERN)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .adv     (lfsr_adv),
    .bit_out (prbs_bit)
  );

`ifdef PRBS_TX_ERR_INJ_EN
  // A pulse is remembered until the next bit boundary; a pulse in the
  // boundary cycle itself applies directly to the bit presented there.
  logic inj_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pend <= 1'b0;
    end else if (state != ST_SEND || wrap) begin
      inj_pend <= 1'b0;
    end else if (inj_err) begin
      inj_pend <= 1'b1;
    end
  end

  assign flip = (state == ST_SEND) && (inj_pend || inj_err);
`else
  assign flip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_stb    <= 1'b0;
      serial_out <= 1'b0;
      mode_q     <= MODE_PRBS;
      spd_q      <= '0;
      rate_cnt   <= '0;
      bit_cnt    <= '0;
      alt_q      <= 1'b1;
    end else begin
      done    <= 1'b0;
      bit_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send_start) begin
            mode_q     <= mode;
            spd_q      <= speedctr;
            rate_cnt   <= '0;
            bit_cnt    <= '0;
            alt_q      <= 1'b1;
            busy       <= 1'b1;
            bit_stb    <= 1'b1;
            serial_out <= pattern_bit(mode, prbs_bit, 1'b1);
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (wrap) begin
            rate_cnt <= '0;
            if (last) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              serial_out <= 1'b0;
              state      <= ST_DONE;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              alt_q      <= ~alt_q;
              bit_stb    <= 1'b1;
              serial_out <= pattern_bit(mode_q, prbs_bit, ~alt_q) ^ flip;
            end
          end else begin
            rate_cnt <= rate_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
